// File: rtl/ramp_dp_vld.sv
// Simple-dual-port scratch RAM with a per-word valid bit, occupancy flags,
// a 1- or 2-cycle read pipeline and a sweeping invalidate FSM.
module ramp_dp_vld #(
    parameter int R      = 5,
    parameter int W      = 3,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [R-1:0]        wr_addr,
    input  logic [(2**W)-1:0]   d_in,
    input  logic                rd_en,
    input  logic [R-1:0]        rd_addr,
    input  logic                clr,
    output logic [(2**W)-1:0]   d_out,
    output logic                rd_vld,
    output logic                rd_hit,
    output logic                busy,
    output logic [R:0]          count,
    output logic                full,
    output logic                empty
);

    localparam int              DEPTH    = 2**R;
    localparam int              DW       = 2**W;
    localparam logic [R:0]      FULL_CNT = (R+1)'(DEPTH);
    localparam logic [R-1:0]    PTR_LAST = {R{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t             state_r;
    logic [R-1:0]       ptr_r;
    logic               busy_r;
    logic [DEPTH-1:0]   valid_r;
    logic [DW-1:0]      mem_r [DEPTH];
    logic [R:0]         count_r;
    logic               full_r;
    logic               empty_r;

    logic               s1_vld_r;
    logic [DW-1:0]      s1_data_r;
    logic               s1_hit_r;

    logic               wr_go_s;
    logic               rd_go_s;
    logic               sweep_s;
    logic [R:0]         count_nxt_s;

    // Port qualification: both ports are only honoured while no sweep is running
    always_comb begin
        wr_go_s = 1'b0;
        rd_go_s = 1'b0;
        sweep_s = 1'b0;
        if (state_r == ST_IDLE) begin
            wr_go_s = wr_en;
            rd_go_s = rd_en;
        end else begin
            sweep_s = 1'b1;
        end
    end

    // Next occupancy: writes and sweeps never coincide, so at most one of them moves count
    always_comb begin
        count_nxt_s = count_r;
        if (wr_go_s && !valid_r[wr_addr]) begin
            count_nxt_s = count_r + 1'b1;
        end else if (sweep_s && valid_r[ptr_r]) begin
            count_nxt_s = count_r - 1'b1;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Clear FSM, valid bits and occupancy flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            busy_r  <= 1'b0;
            valid_r <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (wr_en) begin
                        valid_r[wr_addr] <= 1'b1;
                    end
                    if (clr) begin
                        state_r <= ST_CLEAR;
                        ptr_r   <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    valid_r[ptr_r] <= 1'b0;
                    ptr_r          <= ptr_r + 1'b1;
                    if (ptr_r == PTR_LAST) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == FULL_CNT);
            empty_r <= (count_nxt_s == '0);
        end
    end

    // Storage array, deliberately without reset
    always_ff @(posedge clk) begin
        if (wr_go_s) begin
            mem_r[wr_addr] <= d_in;
        end
    end

    // First read stage; nonblocking update of mem/valid gives read-first on address collision
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_r  <= 1'b0;
            s1_data_r <= '0;
            s1_hit_r  <= 1'b0;
        end else begin
            s1_vld_r <= rd_go_s;
            if (rd_go_s) begin
                s1_data_r <= valid_r[rd_addr] ? mem_r[rd_addr] : '0;
                s1_hit_r  <= valid_r[rd_addr];
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic           s2_vld_r;
            logic [DW-1:0]  s2_data_r;
            logic           s2_hit_r;

            // Second read stage; keeps draining even while a sweep runs
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s2_vld_r  <= 1'b0;
                    s2_data_r <= '0;
                    s2_hit_r  <= 1'b0;
                end else begin
                    s2_vld_r <= s1_vld_r;
                    if (s1_vld_r) begin
                        s2_data_r <= s1_data_r;
                        s2_hit_r  <= s1_hit_r;
                    end
                end
            end

            assign d_out  = s2_data_r;
            assign rd_vld = s2_vld_r;
            assign rd_hit = s2_hit_r;
        end else begin : g_lat1
            assign d_out  = s1_data_r;
            assign rd_vld = s1_vld_r;
            assign rd_hit = s1_hit_r;
        end
    endgenerate

    assign busy  = busy_r;
    assign count = count_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: tb/tb_ramp_dp_vld.sv
// Bench for ramp_dp_vld: RD_LAT=1 and RD_LAT=2 instances share one stimulus
// stream and are checked every cycle against a behavioural model.
module tb_ramp_dp_vld;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, rd_en, clr;
    logic [4:0] wr_addr, rd_addr;
    logic [7:0] d_in;

    logic [7:0] d_out1, d_out2;
    logic       rd_vld1, rd_vld2, rd_hit1, rd_hit2, busy1, busy2;
    logic       full1, full2, empty1, empty2;
    logic [5:0] count1, count2;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    always #5 clk = ~clk;

    ramp_dp_vld #(.R(5), .W(3), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .d_in(d_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .clr(clr), .d_out(d_out1),
        .rd_vld(rd_vld1), .rd_hit(rd_hit1), .busy(busy1), .count(count1),
        .full(full1), .empty(empty1));

    ramp_dp_vld #(.R(5), .W(3), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .d_in(d_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .clr(clr), .d_out(d_out2),
        .rd_vld(rd_vld2), .rd_hit(rd_hit2), .busy(busy2), .count(count2),
        .full(full2), .empty(empty2));

    // Behavioural model: plain arrays, a sweep countdown and a history of read results
    bit [7:0] m_mem [32];
    bit       m_val [32];
    int       sweep_left;
    int       e_count;
    bit       e_busy;
    bit       e1_vld, e1_hit, e2_vld, e2_hit, pv_vld, pv_hit, nv, nh;
    bit [7:0] e1_d, e2_d, pv_d, nd;

    function automatic int occupancy();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_val[i]);
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_val[i] = 1'b0;
            sweep_left = 0;
            e1_vld = 0; e1_hit = 0; e1_d = 8'h00;
            e2_vld = 0; e2_hit = 0; e2_d = 8'h00;
            pv_vld = 0; pv_hit = 0; pv_d = 8'h00;
            e_busy = 0; e_count = 0;
        end else begin
            nv = (sweep_left == 0) && rd_en;
            nh = m_val[rd_addr];
            nd = nh ? m_mem[rd_addr] : 8'h00;
            e2_vld = pv_vld;
            if (pv_vld) begin e2_d = pv_d; e2_hit = pv_hit; end
            pv_vld = nv; pv_d = nd; pv_hit = nh;
            e1_vld = nv;
            if (nv) begin e1_d = nd; e1_hit = nh; end
            if (sweep_left == 0) begin
                if (wr_en) begin
                    m_mem[wr_addr] = d_in;
                    m_val[wr_addr] = 1'b1;
                end
                if (clr) sweep_left = 32;
            end else begin
                m_val[32 - sweep_left] = 1'b0;
                sweep_left--;
            end
            e_busy  = (sweep_left != 0);
            e_count = occupancy();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, half a cycle after the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy1",  32'(busy1),  32'(e_busy));
            chk("count1", 32'(count1), e_count);
            chk("full1",  32'(full1),  32'(e_count == 32));
            chk("empty1", 32'(empty1), 32'(e_count == 0));
            chk("rd_vld1", 32'(rd_vld1), 32'(e1_vld));
            chk("d_out1", 32'(d_out1), 32'(e1_d));
            if (e1_vld) chk("rd_hit1", 32'(rd_hit1), 32'(e1_hit));
            chk("busy2",  32'(busy2),  32'(e_busy));
            chk("count2", 32'(count2), e_count);
            chk("full2",  32'(full2),  32'(e_count == 32));
            chk("empty2", 32'(empty2), 32'(e_count == 0));
            chk("rd_vld2", 32'(rd_vld2), 32'(e2_vld));
            chk("d_out2", 32'(d_out2), 32'(e2_d));
            if (e2_vld) chk("rd_hit2", 32'(rd_hit2), 32'(e2_hit));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    int n;

    initial begin
        rst = 1'b1; quiet();
        wr_addr = 5'd0; rd_addr = 5'd0; d_in = 8'h00;
        #2 rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_count", 32'(count1), 32'd0);
        chk("rst_empty", 32'(empty1), 32'd1);
        chk("rst_full",  32'(full1),  32'd0);
        chk("rst_busy",  32'(busy1),  32'd0);
        chk("rst_dout",  32'(d_out1), 32'd0);
        chk("rst_vld",   32'(rd_vld2), 32'd0);
        step();
        rst = 1'b1;

        // Fill every word with i + A0
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); d_in = 8'hA0 + 8'(i);
            step();
            if (i == 0) chk("empty_after_first", 32'(empty1), 32'd0);
        end
        quiet();
        chk("fill_count", 32'(count1), 32'd32);
        chk("fill_full",  32'(full1),  32'd1);

        // Back-to-back reads on both latencies
        for (int i = 0; i < 32; i++) begin
            rd_en = 1'b1; rd_addr = 5'(i);
            step();
            chk("b2b_vld1", 32'(rd_vld1), 32'd1);
            chk("b2b_d1",   32'(d_out1),  32'(8'hA0 + 8'(i)));
            chk("b2b_hit1", 32'(rd_hit1), 32'd1);
            if (i > 0) chk("b2b_d2", 32'(d_out2), 32'(8'hA0 + 8'(i - 1)));
        end
        quiet();
        step();
        chk("b2b_end_vld1", 32'(rd_vld1), 32'd0);
        chk("b2b_last_d2",  32'(d_out2),  32'hBF);
        chk("b2b_last_v2",  32'(rd_vld2), 32'd1);
        step();
        chk("b2b_end_vld2", 32'(rd_vld2), 32'd0);

        // Miss read and rewrite
        do_reset();
        wr_en = 1'b1; wr_addr = 5'd5; d_in = 8'h3C; step();
        quiet(); rd_en = 1'b1; rd_addr = 5'd6; step();
        chk("miss_hit",   32'(rd_hit1), 32'd0);
        chk("miss_dout",  32'(d_out1),  32'd0);
        chk("miss_count", 32'(count1),  32'd1);
        quiet(); wr_en = 1'b1; wr_addr = 5'd5; d_in = 8'h55; step();
        chk("rewrite_count", 32'(count1), 32'd1);

        // Same-address write and read: read-first
        wr_en = 1'b1; wr_addr = 5'd9; d_in = 8'h12; step();
        wr_en = 1'b1; wr_addr = 5'd9; d_in = 8'hFF; rd_en = 1'b1; rd_addr = 5'd9; step();
        chk("rf_old", 32'(d_out1), 32'h12);
        wr_en = 1'b0; step();
        chk("rf_new", 32'(d_out1), 32'hFF);
        quiet();

        // Full sweep with traffic that must be ignored
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); d_in = 8'($urandom); step();
        end
        quiet(); clr = 1'b1; step(); clr = 1'b0;
        n = 0;
        while (busy1 === 1'b1 && n < 100) begin
            n++;
            chk("sweep_no_vld", 32'(rd_vld1), 32'd0);
            wr_en = 1'(($urandom) & 1); wr_addr = 5'($urandom);
            d_in = 8'($urandom); rd_en = 1'b1; rd_addr = 5'($urandom);
            step();
        end
        quiet();
        chk("sweep_len",   n, 32'd32);
        chk("sweep_count", 32'(count1), 32'd0);
        chk("sweep_empty", 32'(empty1), 32'd1);
        step();

        // Reset in the middle of a sweep
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 5'(3 * i); d_in = 8'(i); step();
        end
        quiet(); clr = 1'b1; step(); clr = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("mid_busy", 32'(busy1), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_busy1",  32'(busy1),  32'd0);
        chk("midrst_count1", 32'(count1), 32'd0);
        chk("midrst_busy2",  32'(busy2),  32'd0);
        step();
        rst = 1'b1;

        // Random traffic, occasional clears and resets
        for (int k = 0; k < 3000; k++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 5'($urandom_range(0, 31));
            d_in    = 8'($urandom);
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            clr     = ($urandom_range(0, 79) == 0);
            rst     = ($urandom_range(0, 499) != 0);
            step();
        end
        rst = 1'b1; quiet();
        step(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
